// File: rtl/spi_ctrl_master.sv
// ============================================================================
// Module      : spi_ctrl_master
// Description : SPI mode-0 initiator that writes one control byte to the CPLD
//               and reads the MISO loopback to confirm delivery.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_ctrl_master #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned NSS_SETUP = 2,
    parameter int unsigned NSS_HOLD  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       echo_ok,
    output logic       SPI_CLK,
    output logic       SPI_MOSI,
    output logic       SPI_NSS,
    input  logic       SPI_MISO
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_LOW   = 3'd2;
    localparam logic [2:0] S_HIGH  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_LAST = 8'(NSS_SETUP - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(NSS_HOLD - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] phase_q, phase_d;
    logic [7:0] bit_q, bit_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;

    logic       nss_q, nss_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       echo_q, echo_d;

    // State register together with all datapath and output flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            phase_q   <= 8'd0;
            bit_q     <= 8'd0;
            tx_q      <= 8'd0;
            rx_q      <= 8'd0;
            nss_q     <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= 8'd0;
            echo_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            nss_q     <= nss_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rx_data_q <= rx_data_d;
            echo_q    <= echo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETUP;
                    tx_d    = tx_data;
                    bit_d   = 8'd7;
                    phase_d = 8'd0;
                    rx_d    = 8'd0;
                end
            end
            S_SETUP: begin
                if (phase_q == SETUP_LAST) begin
                    state_d = S_LOW;
                    phase_d = 8'd0;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            S_LOW: begin
                if (phase_q == DIV_LAST) begin
                    state_d = S_HIGH;
                    phase_d = 8'd0;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            S_HIGH: begin
                if (phase_q == DIV_LAST) begin
                    // Sample MISO on the last high cycle, just before SPI_CLK falls
                    rx_d    = {rx_q[6:0], SPI_MISO};
                    phase_d = 8'd0;
                    if (bit_q == 8'd0) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_LOW;
                        bit_d   = bit_q - 8'd1;
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (phase_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                    phase_d = 8'd0;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up
    // with the state they belong to.
    always_comb begin
        nss_d     = (state_d == S_IDLE);
        sclk_d    = (state_d == S_HIGH);
        mosi_d    = (state_d == S_IDLE) ? 1'b0 : tx_d[bit_d[2:0]];
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_q == S_HOLD) && (state_d == S_IDLE);
        rx_data_d = rx_data_q;
        echo_d    = echo_q;
        if (done_d) begin
            rx_data_d = rx_q;
            echo_d    = (rx_q == tx_q);
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_data  = rx_data_q;
    assign echo_ok  = echo_q;
    assign SPI_CLK  = sclk_q;
    assign SPI_MOSI = mosi_q;
    assign SPI_NSS  = nss_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_ctrl_master.sv
// ============================================================================
// Module      : tb_spi_ctrl_master
// Description : Scoreboard bench for spi_ctrl_master with a CPLD slave model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_ctrl_master;

    typedef struct {
        logic [7:0] slv;
        logic [7:0] rx;
        logic       echo;
        int         lo;
        int         gap;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start   [2];
    logic [7:0] tx      [2];
    logic       busy    [2];
    logic       done    [2];
    logic [7:0] rx_data [2];
    logic       echo    [2];
    logic       sclk    [2];
    logic       mosi    [2];
    logic       nss     [2];
    logic       miso0;
    logic       miso1;
    logic       miso_zero;

    logic [7:0] sh  [2];
    logic [7:0] slv [2];

    exp_t q0[$];
    exp_t q1[$];

    int n_cmp;
    int n_fail;
    int idle_req, idle_ack;
    int end_req, end_ack;

    assign miso0 = miso_zero ? 1'b0 : mosi[0];
    assign miso1 = mosi[1];

    spi_ctrl_master u_dut0 (
        .clk(clk), .reset(rst_n), .start(start[0]), .tx_data(tx[0]),
        .busy(busy[0]), .done(done[0]), .rx_data(rx_data[0]), .echo_ok(echo[0]),
        .SPI_CLK(sclk[0]), .SPI_MOSI(mosi[0]), .SPI_NSS(nss[0]), .SPI_MISO(miso0)
    );

    spi_ctrl_master #(.CLK_DIV(1), .NSS_SETUP(1), .NSS_HOLD(1)) u_dut1 (
        .clk(clk), .reset(rst_n), .start(start[1]), .tx_data(tx[1]),
        .busy(busy[1]), .done(done[1]), .rx_data(rx_data[1]), .echo_ok(echo[1]),
        .SPI_CLK(sclk[1]), .SPI_MOSI(mosi[1]), .SPI_NSS(nss[1]), .SPI_MISO(miso1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // CPLD control-register model: shift on SPI_CLK rise, latch on NSS rise
    initial begin
        sh[0] = 8'h00;
        forever begin
            @(posedge sclk[0]);
            if (!nss[0]) sh[0] = {sh[0][6:0], mosi[0]};
        end
    end
    initial begin
        sh[1] = 8'h00;
        forever begin
            @(posedge sclk[1]);
            if (!nss[1]) sh[1] = {sh[1][6:0], mosi[1]};
        end
    end
    initial begin
        slv[0] = 8'h00;
        forever begin
            @(posedge nss[0]);
            slv[0] = sh[0];
        end
    end
    initial begin
        slv[1] = 8'h00;
        forever begin
            @(posedge nss[1]);
            slv[1] = sh[1];
        end
    end

    task automatic cmp(input string nm, input int i, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d]: got 0x%0h, expected 0x%0h", nm, i, act, exp);
        end
    endtask

    // Monitor: per-transfer NSS/SPI_CLK bookkeeping and scoreboard pops on done
    initial begin
        int   lo    [2];
        int   hi    [2];
        int   edges [2];
        int   gap   [2];
        logic pnss  [2];
        logic pclk  [2];
        exp_t e;
        n_cmp = 0; n_fail = 0; idle_ack = 0; end_ack = 0;
        for (int i = 0; i < 2; i++) begin
            lo[i] = 0; hi[i] = 0; edges[i] = 0; gap[i] = 0;
            pnss[i] = 1'b1; pclk[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!nss[i]) begin
                    if (pnss[i]) begin
                        gap[i] = hi[i]; hi[i] = 0; lo[i] = 0; edges[i] = 0;
                    end
                    lo[i]++;
                    if (sclk[i] && !pclk[i]) edges[i]++;
                end else begin
                    hi[i]++;
                end
                pnss[i] = nss[i];
                pclk[i] = sclk[i];
                if (done[i]) begin
                    if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                        cmp("unexpected_done", i, 1, 0);
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        cmp("slave_ctrl", i, int'(slv[i]), int'(e.slv));
                        cmp("rx_data", i, int'(rx_data[i]), int'(e.rx));
                        cmp("echo_ok", i, int'(echo[i]), int'(e.echo));
                        cmp("nss_low_cycles", i, lo[i], e.lo);
                        cmp("sclk_rises", i, edges[i], 8);
                        if (e.gap >= 0) cmp("nss_high_gap", i, gap[i], e.gap);
                    end
                end
            end
            if (idle_req != idle_ack) begin
                for (int i = 0; i < 2; i++) begin
                    cmp("idle_nss", i, int'(nss[i]), 1);
                    cmp("idle_sclk", i, int'(sclk[i]), 0);
                    cmp("idle_mosi", i, int'(mosi[i]), 0);
                    cmp("idle_busy", i, int'(busy[i]), 0);
                    cmp("idle_done", i, int'(done[i]), 0);
                    cmp("idle_rx_data", i, int'(rx_data[i]), 0);
                    cmp("idle_echo_ok", i, int'(echo[i]), 0);
                end
                idle_ack = idle_req;
            end
            if (end_req != end_ack) begin
                cmp("pending_transfers", 0, q0.size(), 0);
                cmp("pending_transfers", 1, q1.size(), 0);
                end_ack = end_req;
            end
        end
    end

    task automatic expect_xfer(input int i, input logic [7:0] s, input logic [7:0] r,
                               input logic ec, input int lo, input int gap);
        exp_t e;
        e.slv = s; e.rx = r; e.echo = ec; e.lo = lo; e.gap = gap;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic issue(input int i, input logic [7:0] d);
        @(posedge clk); #1;
        start[i] = 1'b1;
        tx[i]    = d;
        @(posedge clk); #1;
        start[i] = 1'b0;
    endtask

    // Returns just after the edge that opens the done cycle
    task automatic wait_done(input int i);
        for (int k = 0; k < 400; k++) begin
            if (done[i]) break;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; miso_zero = 1'b0;
        idle_req = 0; end_req = 0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; tx[i] = 8'h00;
        end
        repeat (4) @(posedge clk);
        #1 idle_req++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle_req++;
        repeat (2) @(posedge clk);

        // Loopback write of 0xA5 with default timing
        expect_xfer(0, 8'hA5, 8'hA5, 1'b1, 68, -1);
        issue(0, 8'hA5);
        wait_done(0);

        // MISO stuck low: slave still gets the byte, echo fails
        @(posedge clk); #1;
        miso_zero = 1'b1;
        expect_xfer(0, 8'hFF, 8'h00, 1'b0, 68, -1);
        issue(0, 8'hFF);
        wait_done(0);
        miso_zero = 1'b0;

        // Starts and tx_data changes while busy are ignored; back-to-back restart
        @(posedge clk); #1;
        expect_xfer(0, 8'h0F, 8'h0F, 1'b1, 68, -1);
        issue(0, 8'h0F);
        repeat (8) @(posedge clk);
        #1 start[0] = 1'b1; tx[0] = 8'hF0;
        @(posedge clk); #1 start[0] = 1'b0;
        repeat (29) @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        wait_done(0);
        expect_xfer(0, 8'h09, 8'h09, 1'b1, 68, 1);
        start[0] = 1'b1; tx[0] = 8'h09;
        @(posedge clk); #1 start[0] = 1'b0;
        wait_done(0);

        // Reset mid-transfer aborts without done, next transfer is clean
        @(posedge clk); #1;
        issue(0, 8'h3C);
        repeat (29) @(posedge clk);
        #1 rst_n = 1'b0;
        idle_req++;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        expect_xfer(0, 8'h01, 8'h01, 1'b1, 68, -1);
        issue(0, 8'h01);
        wait_done(0);

        // Fastest legal timing
        @(posedge clk); #1;
        expect_xfer(1, 8'h3C, 8'h3C, 1'b1, 18, -1);
        issue(1, 8'h3C);
        wait_done(1);
        expect_xfer(1, 8'h81, 8'h81, 1'b1, 18, 1);
        start[1] = 1'b1; tx[1] = 8'h81;
        @(posedge clk); #1 start[1] = 1'b0;
        wait_done(1);

        repeat (4) @(posedge clk);
        #1 end_req++;
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
